// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache between fetch and backing memory.
// A hit returns FETCH_WIDTH words one cycle after the request is accepted; a miss refills
// one whole line through a valid/ready request port and a single-beat valid-only response.
// Optional feature macro: ICACHE_PERF_EN adds 32-bit hit/miss counters (perf_hits, perf_misses).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | no request in flight
// S_LOOKUP  | registered address checked against tag/valid; a hit responds now
// S_MISS_REQ| refill request presented to memory, waiting for mem_req_rdy
// S_MISS_WAIT| waiting for the refill beat; the line is installed even if flushed
// S_RESPOND | refilled data presented to fetch
module icache_dm #(
    parameter int NUM_SETS    = 64,
    parameter int LINE_WORDS  = 4,
    parameter int FETCH_WIDTH = 2,
    parameter int ADDR_BITS   = 32
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef ICACHE_PERF_EN
    output logic [31:0]                 perf_hits,
    output logic [31:0]                 perf_misses,
`endif
    input  logic                        flush,
    input  logic [ADDR_BITS-1:0]        icache_addr,
    input  logic                        icache_re,
    output logic [FETCH_WIDTH*32-1:0]   icache_dout,
    output logic                        icache_dout_val,
    output logic                        icache_dout_part,
    output logic                        icache_stall,
    output logic [ADDR_BITS-1:0]        mem_req_addr,
    output logic                        mem_req_val,
    input  logic                        mem_req_rdy,
    input  logic [LINE_WORDS*32-1:0]    mem_resp_data,
    input  logic                        mem_resp_val
);

    localparam int OFF_W     = $clog2(LINE_WORDS);
    localparam int IDX_W     = $clog2(NUM_SETS);
    localparam int TAG_W     = ADDR_BITS - IDX_W - OFF_W - 2;
    localparam int LINE_BITS = LINE_WORDS * 32;
    localparam int OUT_BITS  = FETCH_WIDTH * 32;
    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_REQ,
        S_MISS_WAIT,
        S_RESPOND
    } state_t;

    state_t               state_q, state_d;
    logic [OFF_W-1:0]     off_q;
    logic [IDX_W-1:0]     idx_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 kill_q, kill_d;
    logic [NUM_SETS-1:0]  valid_q;
    logic [TAG_W-1:0]     tag_arr [NUM_SETS];
    logic [LINE_BITS-1:0] data_arr [NUM_SETS];
    logic [OUT_BITS-1:0]  dout_q;

    logic [OFF_W-1:0]     in_off;
    logic [IDX_W-1:0]     in_idx;
    logic [TAG_W-1:0]     in_tag;
    logic                 in_hit;
    logic                 lookup_hit;
    logic                 accept;
    logic                 refill_we;
    logic                 hit_evt;
    logic                 miss_evt;
    logic                 unused_addr_lsb;

    assign in_off = icache_addr[OFF_W+1:2];
    assign in_idx = icache_addr[OFF_W+2 +: IDX_W];
    assign in_tag = icache_addr[ADDR_BITS-1 -: TAG_W];
    assign unused_addr_lsb = ^icache_addr[1:0];

    // Hit for the incoming address decides whether dout is reloaded at accept, so that
    // dout only changes when it is about to be presented.
    assign in_hit     = valid_q[in_idx] && (tag_arr[in_idx] == in_tag);
    assign lookup_hit = valid_q[idx_q] && (tag_arr[idx_q] == tag_q);

    // Slots that run past the end of the line are filled with NOPs.
    function automatic logic [OUT_BITS-1:0] pack_fetch(input logic [LINE_BITS-1:0] line,
                                                       input logic [OFF_W-1:0] off);
        int w;
        pack_fetch = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            w = int'(off) + i;
            if (w < LINE_WORDS) pack_fetch[i*32 +: 32] = line[w*32 +: 32];
            else                pack_fetch[i*32 +: 32] = NOP_WORD;
        end
    endfunction

    // Next-state and handshake outputs.
    always_comb begin
        state_d         = state_q;
        kill_d          = kill_q;
        icache_stall    = 1'b0;
        icache_dout_val = 1'b0;
        mem_req_val     = 1'b0;
        accept          = 1'b0;
        refill_we       = 1'b0;
        hit_evt         = 1'b0;
        miss_evt        = 1'b0;
        case (state_q)
            S_IDLE: begin
                accept  = icache_re && !flush;
                state_d = accept ? S_LOOKUP : S_IDLE;
            end
            S_LOOKUP: begin
                if (lookup_hit) begin
                    icache_dout_val = !flush;
                    hit_evt         = !flush;
                    accept          = icache_re && !flush;
                    state_d         = accept ? S_LOOKUP : S_IDLE;
                end else begin
                    icache_stall = 1'b1;
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_MISS_REQ;
                        miss_evt = 1'b1;
                    end
                end
            end
            S_MISS_REQ: begin
                icache_stall = 1'b1;
                kill_d       = 1'b0;
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    mem_req_val = 1'b1;
                    if (mem_req_rdy) state_d = S_MISS_WAIT;
                end
            end
            S_MISS_WAIT: begin
                icache_stall = 1'b1;
                if (flush) kill_d = 1'b1;
                if (mem_resp_val) begin
                    refill_we = 1'b1;
                    state_d   = (kill_q || flush) ? S_IDLE : S_RESPOND;
                end
            end
            S_RESPOND: begin
                icache_dout_val = !flush;
                accept          = icache_re && !flush;
                state_d         = accept ? S_LOOKUP : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign icache_dout      = dout_q;
    assign icache_dout_part = icache_dout_val && (int'(off_q) > LINE_WORDS - FETCH_WIDTH);
    assign mem_req_addr     = {tag_q, idx_q, {(OFF_W+2){1'b0}}};

    // State register and the refill kill flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
        end
    end

    // Capture the accepted fetch address; it also drives the refill address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            off_q <= '0;
            idx_q <= '0;
            tag_q <= '0;
        end else if (accept) begin
            off_q <= in_off;
            idx_q <= in_idx;
            tag_q <= in_tag;
        end
    end

    // Output data register: loaded for a predicted hit at accept, or from the refill beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
        end else if (refill_we && !kill_q && !flush) begin
            dout_q <= pack_fetch(mem_resp_data, off_q);
        end else if (accept && in_hit) begin
            dout_q <= pack_fetch(data_arr[in_idx], in_off);
        end
    end

    // Valid bits are the only reset storage; a refill marks its line present.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (refill_we) begin
            valid_q[idx_q] <= 1'b1;
        end
    end

    // Tag and data arrays, written only by a refill.
    always_ff @(posedge clk) begin
        if (refill_we) begin
            tag_arr[idx_q]  <= tag_q;
            data_arr[idx_q] <= mem_resp_data;
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] hits_q, misses_q;

    // Event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            if (hit_evt)  hits_q   <= hits_q + 32'd1;
            if (miss_evt) misses_q <= misses_q + 32'd1;
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`else
    logic unused_perf;
    assign unused_perf = hit_evt ^ miss_evt;
`endif

endmodule
